// File: rtl/timer_irq_pkg.sv
// Shared definitions for the countdown interrupt timer: FSM state encoding,
// word offsets of the memory-mapped registers, CTRL bit positions and MODE codes.
package timer_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Word offsets (byte offset >> 2)
  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_PRESET   = 1;
  localparam int unsigned REG_COUNT    = 2;
  localparam int unsigned REG_PRESCALE = 3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;
  localparam int unsigned CTRL_PEND_BIT = 4;

  // MODE codes; 10/11 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Assemble the CTRL read value; unused bits read 0
  function automatic logic [31:0] ctrl_pack(input logic       en,
                                            input logic [1:0] mode,
                                            input logic       im,
                                            input logic       pend);
    logic [31:0] v;
    v                       = '0;
    v[CTRL_EN_BIT]          = en;
    v[CTRL_MODE_LSB +: 2]   = mode;
    v[CTRL_IM_BIT]          = im;
    v[CTRL_PEND_BIT]        = pend;
    return v;
  endfunction

endpackage

// File: rtl/timer_prescale.sv
// Free-running clock divider for the timer: tick is high one cycle in every
// div+1 cycles; restart forces the phase back to the start of a period.
// Ports: clk, rst_n (async active-low), restart, div[PRESCALE_W-1:0], tick.
module timer_prescale
  import timer_irq_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // >= keeps the divider from running the full counter range when div shrinks
  assign tick = (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q + PRESCALE_W'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_irq.sv
// Programmable 32-bit countdown timer with a level interrupt (irq = PEND & IM)
// on the CPU device bus. Registers: CTRL (0x0), PRESET (0x4), COUNT (0x8, RO),
// PRESCALE (0xC, only when TIMER_PRESCALE_EN is defined; otherwise reads 0).
// Ports: clk, rst_n (async active-low), addr (word select), we, din[31:0],
//        dout[31:0] (combinational read of addr), irq (level).
// Build option: `define TIMER_PRESCALE_EN to add the prescaler.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned BASE_SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BASE_SEL_W-1:0] addr,
  input  logic                  we,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic                  irq
);

  timer_state_e state_q, state_d;

  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        en_eff;
  logic [1:0]  mode_eff;
  logic        tick;
  logic [PRESCALE_W-1:0] prescale_rd;

  assign ctrl_wr   = we && (addr == BASE_SEL_W'(REG_CTRL));
  assign preset_wr = we && (addr == BASE_SEL_W'(REG_PRESET));

  // A CTRL write in this cycle takes effect on the FSM at the same edge
  assign en_eff   = ctrl_wr ? din[CTRL_EN_BIT]        : en_q;
  assign mode_eff = ctrl_wr ? din[CTRL_MODE_LSB +: 2] : mode_q;

`ifdef TIMER_PRESCALE_EN
  logic                  prescale_wr;
  logic                  prescale_restart;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  assign prescale_wr      = we && (addr == BASE_SEL_W'(REG_PRESCALE));
  assign prescale_restart = (state_q == ST_LOAD);

  always_comb begin
    prescale_d = prescale_q;
    if (prescale_wr) prescale_d = din[PRESCALE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prescale_q <= '0;
    else        prescale_q <= prescale_d;
  end

  timer_prescale #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescale (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (prescale_restart),
    .div     (prescale_q),
    .tick    (tick)
  );

  assign prescale_rd = prescale_q;
`else
  assign tick        = 1'b1;
  assign prescale_rd = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en_eff) state_d = ST_LOAD;
      ST_LOAD: state_d = en_eff ? ST_CNT : ST_IDLE;
      ST_CNT: begin
        if (!en_eff)                              state_d = ST_IDLE;
        else if (tick && (count_q <= 32'd1))      state_d = ST_INT;
      end
      ST_INT: begin
        if (en_eff && (mode_eff == MODE_RELOAD))  state_d = ST_LOAD;
        else                                      state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register/datapath updates driven by the current state
  always_comb begin
    en_d     = en_eff;
    mode_d   = mode_eff;
    im_d     = ctrl_wr ? din[CTRL_IM_BIT] : im_q;
    pend_d   = ctrl_wr ? 1'b0 : pend_q;
    preset_d = preset_wr ? din : preset_q;
    count_d  = count_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_LOAD: count_d = preset_q;
      ST_CNT: begin
        // PRESET of 0 or 1 both end the count on the first tick
        if (en_eff && tick) count_d = (count_q > 32'd1) ? count_q - 32'd1 : 32'd0;
      end
      ST_INT: begin
        // Interrupt set beats a coincident acknowledge
        pend_d = 1'b1;
        if (!ctrl_wr && (mode_q != MODE_RELOAD)) en_d = 1'b0;
      end
      default: ;
    endcase
    irq_d = pend_d & im_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  assign irq = irq_q;

  // Bus read mux, no side effects
  always_comb begin
    dout = '0;
    case (addr)
      BASE_SEL_W'(REG_CTRL):     dout = ctrl_pack(en_q, mode_q, im_q, pend_q);
      BASE_SEL_W'(REG_PRESET):   dout = preset_q;
      BASE_SEL_W'(REG_COUNT):    dout = count_q;
      BASE_SEL_W'(REG_PRESCALE): dout = 32'(prescale_rd);
      default:                   dout = '0;
    endcase
  end

endmodule
